mem_wb_unit: RTL and testbench
==============================

# mem_wb_unit

Multi-cycle memory-access and writeback stage: the write-side counterpart to the decode/register-read block. It accepts one executed instruction per handshake and performs any data-memory load or store over a req/ack bus with wait states. It then drives the register-file write port (WE3/A3/WD3) with the selected, aligned and extended result. It sits between the ALU output and the register file of the multi-cycle core.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  executed instruction presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- ALUResult  in  32  ALU result; this is the memory byte address for loads and stores.
- WriteData  in  32  store data (RD2).
- PCPlus4  in  32  link value for jumps.
- funct3  in  3  access size and sign.
- rd  in  5  destination register.
- RegWrite, MemWrite, ResultSrc, Jump  in  1 each  control; ResultSrc=1 means load.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address: {ALUResult[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  completes the request this cycle.
- WE3  out  1  register write strobe, one cycle.
- A3  out  5  write address.
- WD3  out  32  write data.
- misalign  out  1  only present with MISALIGN_TRAP_EN.

## Operation
- States: IDLE, MEM, WB.
- **IDLE**
  - Captures all inputs into holding registers on in_valid && in_ready.
  - Goes to MEM if MemWrite or ResultSrc; otherwise goes to WB.
- **MEM**
  - mem_req=1.
  - mem_addr, mem_we, mem_be and mem_wdata come from the holding registers and stay stable until ack.
  - On mem_ack:
    - Load: capture mem_rdata and go to WB.
    - Store: go to IDLE.
- **WB**
  - WE3 = RegWrite && (rd != 0).
  - Always returns to IDLE.
- Result select:
  - Jump gives PCPlus4.
  - Load gives the extracted value.
  - Anything else gives ALUResult.
  - Jump has priority over load.
- Load extract, with byte offset o = addr[1:0]:
  - 000 LB: sign-extend byte o.
  - 100 LBU: zero-extend byte o.
  - 001 LH: sign-extend half addr[1].
  - 101 LHU: zero-extend half addr[1].
  - 010, and any other code: word.
- Store:
  - 000 SB: be = 4'b0001<<o; wdata = byte replicated ×4.
  - 001 SH: be = 4'b0011<<{addr[1],1'b0}; wdata = half replicated ×2.
  - Other codes: be = 4'b1111; wdata = WriteData.
- mem_ack outside MEM is ignored.
- A load or store with RegWrite=1 still obeys the above; a store never asserts WE3.
- Reset values:
  - State IDLE.
  - in_ready=1.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - WE3=0, A3=0, WD3=0, misalign=0.
- Reset mid-operation: an outstanding request is abandoned; mem_req is 0 the cycle after rst and no WE3 is issued.

## Timing
- Non-memory op accepted at edge N: WE3 high in cycle N+1 only; in_ready back high in cycle N+2.
- Load accepted at N: mem_req high from N+1.
  - With ack in N+1+k: WE3 high in N+2+k.
  - Zero-wait ack (k=0) gives a 2-cycle load latency.
- Store accepted at N: mem_req from N+1; IDLE in the cycle after ack.
- WD3 and A3 are valid whenever WE3=1; otherwise they hold their last value.
- The register file samples WD3 at the edge ending the WB cycle.
- Peak throughput: one instruction per 2 cycles.

## Configuration
- MISALIGN_TRAP_EN defined:
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, skips MEM.
  - misalign pulses high for one cycle (the cycle after accept), with no mem_req and no WE3.
  - The unit then returns to IDLE.
- Undefined:
  - No misalign port.
  - The access proceeds with the low address bits ignored for word/half alignment, per the extract and store rules.

## Test plan
- ADD result: ALUResult=0x0000_1234, rd=5, RegWrite=1 -> WE3 one cycle after accept with A3=5, WD3=0x1234.
- rd=0 with RegWrite=1 -> WE3 stays 0 throughout.
- LB, addr 0x103, mem_rdata=0x80FF_EE11, ack after 3 wait cycles -> mem_addr=0x100, mem_req held 4 cycles, WD3=0xFFFF_FF80. Repeat as LBU -> WD3=0x0000_0080.
- SH, addr 0x202, WriteData=0xDEAD_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1, no WE3.
- JAL: Jump=1, PCPlus4=0x44, ResultSrc=1 -> no mem_req, WD3=0x44.
- rst asserted during the wait of a load -> mem_req=0 next cycle, in_ready=1, no WE3. With MISALIGN_TRAP_EN: LW at 0x6 -> misalign pulse, no mem_req.

Source files
------------

// File: rtl/mem_wb_unit.sv
// mem_wb_unit: multi-cycle memory-access and register writeback stage.
// Accepts one executed instruction per handshake, performs an optional
// load/store over a req/ack bus with wait states, then drives WE3/A3/WD3.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (adds the misalign output).
module mem_wb_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] PCPlus4,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic                  ResultSrc,
  input  logic                  Jump,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  WE3,
  output logic [4:0]            A3,
  output logic [DATA_WIDTH-1:0] WD3
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  localparam int unsigned BE_W  = 4;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_next;

  // Holding registers for the instruction in flight
  logic [1:0]       hold_off;
  logic [2:0]       hold_f3;
  logic [REG_W-1:0] hold_rd;
  logic             hold_regw;
  logic             hold_store;

  logic                  accept;
  logic                  is_mem_in;
  logic [1:0]            off_in;
  logic [BE_W-1:0]       be_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic                  mis_in;
  logic [DATA_WIDTH-1:0] load_val;

  logic                  req_next;
  logic                  we3_next;
  logic [REG_W-1:0]      a3_next;
  logic [DATA_WIDTH-1:0] wd3_next;
  logic                  mis_next;

  assign accept = in_valid && (state == S_IDLE);
  assign off_in = ALUResult[1:0];
  // A jump never touches memory, even when ResultSrc is also set
  assign is_mem_in = MemWrite || (ResultSrc && !Jump);

  // Byte-lane enables and replicated store data from the incoming op
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = WriteData;
    if (MemWrite) begin
      case (funct3)
        3'b000: begin
          be_in    = 4'(4'b0001 << off_in);
          wdata_in = {4{WriteData[7:0]}};
        end
        3'b001: begin
          be_in    = 4'(4'b0011 << {off_in[1], 1'b0});
          wdata_in = {2{WriteData[15:0]}};
        end
        default: ;
      endcase
    end else begin
      case (funct3[1:0])
        2'b00:   be_in = 4'(4'b0001 << off_in);
        2'b01:   be_in = 4'(4'b0011 << {off_in[1], 1'b0});
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic size_half;
  logic size_word;

  // Access-size decode and alignment fault detection for incoming op
  always_comb begin
    size_half = 1'b0;
    size_word = 1'b0;
    if (MemWrite) begin
      size_half = (funct3 == 3'b001);
      size_word = (funct3 != 3'b000) && (funct3 != 3'b001);
    end else begin
      size_half = (funct3[1:0] == 2'b01);
      size_word = funct3[1];
    end
    mis_in = is_mem_in &&
             ((size_half && off_in[0]) || (size_word && (off_in != 2'b00)));
  end
`else
  assign mis_in = 1'b0;
`endif

  // Load data extraction, alignment and extension from held address/size
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (hold_off)
      2'b00:   byte_v = mem_rdata[7:0];
      2'b01:   byte_v = mem_rdata[15:8];
      2'b10:   byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = hold_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (hold_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    req_next   = mem_req;
    we3_next   = 1'b0;
    a3_next    = A3;
    wd3_next   = WD3;
    mis_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (mis_in) begin
            state_next = S_WB;
            mis_next   = 1'b1;
          end else if (is_mem_in) begin
            state_next = S_MEM;
            req_next   = 1'b1;
          end else begin
            state_next = S_WB;
            we3_next   = RegWrite && (rd != 5'd0);
            if (we3_next) begin
              a3_next  = rd;
              wd3_next = Jump ? PCPlus4 : ALUResult;
            end
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          req_next = 1'b0;
          if (hold_store) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_WB;
            we3_next   = hold_regw && (hold_rd != 5'd0);
            if (we3_next) begin
              a3_next  = hold_rd;
              wd3_next = load_val;
            end
          end
        end
      end
      S_WB: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      mem_req  <= 1'b0;
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_IDLE);
      mem_req  <= req_next;
      WE3      <= we3_next;
      A3       <= a3_next;
      WD3      <= wd3_next;
    end
  end

  // Memory command registers, loaded on accept of an aligned memory op
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (accept && is_mem_in && !mis_in) begin
      mem_we    <= MemWrite;
      mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
      mem_wdata <= wdata_in;
      mem_be    <= be_in;
    end
  end

  // Holding registers for writeback of a load
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_off   <= 2'b00;
      hold_f3    <= 3'b000;
      hold_rd    <= '0;
      hold_regw  <= 1'b0;
      hold_store <= 1'b0;
    end else if (accept) begin
      hold_off   <= off_in;
      hold_f3    <= funct3;
      hold_rd    <= rd;
      hold_regw  <= RegWrite;
      hold_store <= MemWrite;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle misalignment trap pulse
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_next;
  end
`endif

endmodule

// File: tb/tb_mem_wb_unit.sv
// Self-checking bench for mem_wb_unit with a behavioural transaction model.
// Build with MISALIGN_TRAP_EN defined to also exercise the trap path.
module tb_mem_wb_unit;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        regw;
    logic        memw;
    logic        rsrc;
    logic        jump;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUResult, WriteData, PCPlus4;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        RegWrite, MemWrite, ResultSrc, Jump;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        mis_obs;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
  assign mis_obs = misalign;
`else
  assign mis_obs = 1'b0;
`endif

  mem_wb_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .WriteData(WriteData), .PCPlus4(PCPlus4),
    .funct3(funct3), .rd(rd), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .Jump(Jump), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .WE3(WE3), .A3(A3), .WD3(WD3)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by do_op
  int          o_req_cnt, o_we_cnt, o_we_cyc, o_end_cyc, o_mis_cnt;
  logic        o_timeout, o_unstable, o_we;
  logic [31:0] o_addr, o_wdata, o_wd3;
  logic [3:0]  o_be;
  logic [4:0]  o_a3;

  // Expectations from the model
  logic        e_mem, e_store, e_we3, e_mis;
  logic [31:0] e_addr, e_wdata, e_wd3;
  logic [3:0]  e_be;
  int          e_end, e_we_cyc;

  // Behavioural model: what one transaction should do, from the rules
  task automatic model(input op_t op, input int k, input logic [31:0] rdata);
    int unsigned a, bsel, hsel, bytev, halfv;
    logic is_half, is_word;
    a      = op.alu % 4;
    e_mem  = !op.jump && (op.memw || op.rsrc);
    e_store = e_mem && op.memw;
    e_addr = op.alu - a;
    e_be = 4'hF;
    e_wdata = op.wd;
    if (op.f3 == 3'd0) begin
      e_be = 4'(1 << a);
      e_wdata = (op.wd % 256) * 32'h0101_0101;
    end else if (op.f3 == 3'd1) begin
      e_be = 4'(3 << ((a / 2) * 2));
      e_wdata = (op.wd % 65536) * 32'h0001_0001;
    end
    bsel  = 8 * a;
    bytev = (rdata >> bsel) % 256;
    hsel  = (a >= 2) ? 16 : 0;
    halfv = (rdata >> hsel) % 65536;
    if (op.jump)              e_wd3 = op.pc4;
    else if (e_mem) begin
      case (op.f3)
        3'd0: e_wd3 = (bytev >= 128) ? (bytev + 32'hFFFF_FF00) : bytev;
        3'd4: e_wd3 = bytev;
        3'd1: e_wd3 = (halfv >= 32768) ? (halfv + 32'hFFFF_0000) : halfv;
        3'd5: e_wd3 = halfv;
        default: e_wd3 = rdata;
      endcase
    end else                  e_wd3 = op.alu;
    e_mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (op.memw) begin
      is_half = (op.f3 == 3'd1);
      is_word = (op.f3 != 3'd0) && (op.f3 != 3'd1);
    end else begin
      is_half = (op.f3 % 4 == 1);
      is_word = (op.f3 % 4 >= 2);
    end
    e_mis = e_mem && ((is_half && (a % 2 == 1)) || (is_word && a != 0));
`else
    is_half = 1'b0;
    is_word = 1'b0;
`endif
    e_we3 = op.regw && (op.rd != 0) && !e_store && !e_mis;
    if (e_mis || !e_mem) begin
      e_end = 2; e_we_cyc = 1;
    end else if (e_store) begin
      e_end = k + 2; e_we_cyc = 0;
    end else begin
      e_end = k + 3; e_we_cyc = k + 2;
    end
    if (!e_we3) e_we_cyc = 0;
  endtask

  // Drive one instruction, service the bus with k wait states, observe
  task automatic do_op(input op_t op, input int k, input logic [31:0] rdata);
    int guard = 0;
    o_timeout = 1'b0; o_unstable = 1'b0;
    o_req_cnt = 0; o_we_cnt = 0; o_we_cyc = 0; o_end_cyc = 0; o_mis_cnt = 0;
    o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0; o_wd3 = '0; o_a3 = '0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin o_timeout = 1'b1; return; end
    ALUResult = op.alu; WriteData = op.wd; PCPlus4 = op.pc4; funct3 = op.f3;
    rd = op.rd; RegWrite = op.regw; MemWrite = op.memw; ResultSrc = op.rsrc;
    Jump = op.jump; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_ack = 1'b0;
      if (in_ready) begin o_end_cyc = cyc; break; end
      if (mem_req) begin
        if (o_req_cnt == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
        end else if (o_addr !== mem_addr || o_wdata !== mem_wdata ||
                     o_be !== mem_be || o_we !== mem_we) begin
          o_unstable = 1'b1;
        end
        o_req_cnt++;
        if (o_req_cnt == k + 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end
      if (WE3) begin o_we_cnt++; o_we_cyc = cyc; o_a3 = A3; o_wd3 = WD3; end
      if (mis_obs) o_mis_cnt++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    if (o_end_cyc == 0) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ALUResult = '0; WriteData = '0; PCPlus4 = '0; funct3 = '0; rd = '0;
    RegWrite = 0; MemWrite = 0; ResultSrc = 0; Jump = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({in_ready, mem_req, mem_we, mem_be, WE3, mis_obs} !== 10'b1_0_0_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b req=%b we=%b be=%b WE3=%b mis=%b",
               in_ready, mem_req, mem_we, mem_be, WE3, mis_obs);
    end
    n_tests++;
    if (mem_addr !== 0 || mem_wdata !== 0 || A3 !== 0 || WD3 !== 0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h A3=%0d WD3=%h, want all 0",
               mem_addr, mem_wdata, A3, WD3);
    end
  endtask

  // Common check of a finished transaction against the model
  task automatic test_op(input string name, input op_t op, input int k,
                         input logic [31:0] rdata);
    model(op, k, rdata);
    do_op(op, k, rdata);
    n_tests++;
    if (o_timeout) begin
      n_fail++; $display("FAIL %s_timeout: no return to idle", name);
      return;
    end
    n_tests++;
    if (o_end_cyc != e_end) begin
      n_fail++; $display("FAIL %s_latency: ready at cyc %0d want %0d", name, o_end_cyc, e_end);
    end
    n_tests++;
    if (o_req_cnt != ((e_mem && !e_mis) ? k + 1 : 0) || o_unstable) begin
      n_fail++;
      $display("FAIL %s_req: req cycles %0d unstable=%b want %0d", name, o_req_cnt,
               o_unstable, (e_mem && !e_mis) ? k + 1 : 0);
    end
    if (e_mem && !e_mis) begin
      n_tests++;
      if (o_addr !== e_addr || o_we !== e_store) begin
        n_fail++;
        $display("FAIL %s_addr: addr=%h we=%b want %h %b", name, o_addr, o_we, e_addr, e_store);
      end
    end
    if (e_store && !e_mis) begin
      n_tests++;
      if (o_be !== e_be || o_wdata !== e_wdata) begin
        n_fail++;
        $display("FAIL %s_store: be=%b wdata=%h want %b %h", name, o_be, o_wdata, e_be, e_wdata);
      end
    end
    n_tests++;
    if (o_we_cnt != (e_we3 ? 1 : 0) || o_we_cyc != e_we_cyc) begin
      n_fail++;
      $display("FAIL %s_we3: count %0d at cyc %0d want %0d at %0d", name, o_we_cnt,
               o_we_cyc, e_we3 ? 1 : 0, e_we_cyc);
    end
    if (e_we3) begin
      n_tests++;
      if (o_a3 !== op.rd || o_wd3 !== e_wd3) begin
        n_fail++;
        $display("FAIL %s_wb: A3=%0d WD3=%h want %0d %h", name, o_a3, o_wd3, op.rd, e_wd3);
      end
    end
    n_tests++;
    if (o_mis_cnt != (e_mis ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_misalign: pulses %0d want %0d", name, o_mis_cnt, e_mis ? 1 : 0);
    end
  endtask

  task automatic test_directed();
    op_t op;
    op = '{alu:32'h1234, wd:0, pc4:32'h8, f3:3'd0, rd:5'd5, regw:1, memw:0, rsrc:0, jump:0};
    test_op("add", op, 0, 0);
    op.rd = 5'd0;
    test_op("rd0", op, 0, 0);
    op = '{alu:32'h103, wd:0, pc4:0, f3:3'd0, rd:5'd7, regw:1, memw:0, rsrc:1, jump:0};
    test_op("lb", op, 3, 32'h80FF_EE11);
    n_tests++;
    if (o_wd3 !== 32'hFFFF_FF80 || o_req_cnt != 4 || o_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL lb_const: WD3=%h req=%0d addr=%h want ffffff80 4 00000100",
               o_wd3, o_req_cnt, o_addr);
    end
    op.f3 = 3'd4;
    test_op("lbu", op, 3, 32'h80FF_EE11);
    n_tests++;
    if (o_wd3 !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu_const: WD3=%h want 00000080", o_wd3);
    end
    op = '{alu:32'h202, wd:32'hDEAD_BEEF, pc4:0, f3:3'd1, rd:5'd9, regw:1, memw:1, rsrc:0, jump:0};
    test_op("sh", op, 1, 0);
    n_tests++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF || o_we !== 1'b1 || o_we_cnt != 0) begin
      n_fail++;
      $display("FAIL sh_const: be=%b wdata=%h we=%b WE3 count=%0d want 1100 beefbeef 1 0",
               o_be, o_wdata, o_we, o_we_cnt);
    end
    op = '{alu:32'h500, wd:0, pc4:32'h44, f3:3'd2, rd:5'd1, regw:1, memw:0, rsrc:1, jump:1};
    test_op("jal", op, 0, 0);
    n_tests++;
    if (o_req_cnt != 0 || o_wd3 !== 32'h44) begin
      n_fail++; $display("FAIL jal_const: req=%0d WD3=%h want 0 00000044", o_req_cnt, o_wd3);
    end
    op = '{alu:32'h10, wd:0, pc4:0, f3:3'd2, rd:5'd3, regw:1, memw:0, rsrc:1, jump:0};
    test_op("lw_fast", op, 0, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    op_t op;
    int kind, k;
    logic [31:0] rdata;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      op.alu = $urandom; op.wd = $urandom; op.pc4 = $urandom;
      op.f3 = 3'($urandom_range(0, 7));
      op.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      op.regw = 1'($urandom_range(0, 1)) | (kind != 2);
      op.memw = (kind == 2);
      op.rsrc = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      op.jump = (kind == 3);
      k = $urandom_range(0, 3);
      rdata = $urandom;
      test_op("rand", op, k, rdata);
    end
  endtask

  task automatic test_ack_idle();
    int bad = 0;
    for (int c = 0; c < 4; c++) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      if (mem_req || WE3 || !in_ready) bad++;
    end
    mem_ack = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ack_idle: %0d disturbed cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int we_seen = 0;
    int req_seen = 0;
    ALUResult = 32'h40; funct3 = 3'd2; rd = 5'd4; RegWrite = 1;
    MemWrite = 0; ResultSrc = 1; Jump = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: mem_req=%b want 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1 || WE3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_post: req=%b ready=%b WE3=%b want 0 1 0", mem_req, in_ready, WE3);
    end
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 0); mem_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      if (WE3) we_seen++;
      if (mem_req) req_seen++;
    end
    mem_ack = 1'b0;
    n_tests++;
    if (we_seen != 0 || req_seen != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: WE3 %0d req %0d want 0 0", we_seen, req_seen);
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    op_t op;
    op = '{alu:32'h6, wd:0, pc4:0, f3:3'd2, rd:5'd8, regw:1, memw:0, rsrc:1, jump:0};
    test_op("lw_mis", op, 0, 0);
    n_tests++;
    if (o_mis_cnt != 1 || o_req_cnt != 0 || o_we_cnt != 0) begin
      n_fail++;
      $display("FAIL lw_mis_const: mis=%0d req=%0d we=%0d want 1 0 0",
               o_mis_cnt, o_req_cnt, o_we_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ack_idle();
    test_random();
    test_reset_mid();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
